hpm_event_ctrl: RTL and testbench
=================================

// Module: hpm_event_ctrl
// PURPOSE
//  Event-selection and overflow controller for programmable HPM counters 3..COUNTERS-1 (Zihpm + Sscofpmf).
//  Holds mhpmevent3..31 (+ mhpmeventh on RV32) and applies per-privilege inhibit filtering to the event sources.
//  Drives per-counter increment enables into the counter CSR file and tracks sticky overflow (OF) bits.
//  Raises the local-counter-overflow interrupt (LCOFI) request and serves scountovf.
// PARAMETERS
//  XLEN       64  datapath width; 32 enables mhpmeventh (0x723-0x73F)
//  COUNTERS   32  implemented counters; slots 3..COUNTERS-1 are controlled here
//  NUMEVENTS  32  event sources; legal selector values 1..NUMEVENTS-1
// PORTS
//  clk               in   1          core clock
//  reset             in   1          asynchronous, active-low reset
//  CSRMWriteM        in   1          M-level CSR write strobe (already qualified by valid instr)
//  CSRAdrM           in   12         CSR address
//  CSRWriteValM      in   XLEN       CSR write data
//  PrivilegeModeW    in   2          current privilege (M=3,S=1,U=0)
//  VirtModeW         in   1          V bit
//  MCOUNTEREN_REGW   in   32         mcounteren, gates scountovf visibility
//  EventSrcM         in   NUMEVENTS  raw one-cycle event pulses; bit 0 unused
//  CounterOvfM       in   COUNTERS   carry out of 64-bit counter on an enabled increment
//  CountEnM          out  COUNTERS   per-counter increment enable; bits 2:0 always 0
//  EventReadValM     out  XLEN       read data for mhpmevent/mhpmeventh/scountovf
//  EventHitM         out  1          CSRAdrM decodes into this block
//  IllegalEventAccessM out 1         scountovf read from U/VU mode, or any write to scountovf
//  LCOFIRequestM     out  1          one-cycle pulse: set mip.LCOFIP
// BEHAVIOUR
//  - Per-slot state: OF, MINH, SINH, UINH, VSINH, VUINH (RV64 bits 63..58; RV32 mhpmeventh bits 31..26),
//    SEL[7:0] (bits 7:0). All other bits are WARL, read 0. Writes of any SEL value are stored; values 0 or
//    >=NUMEVENTS select no event.
//  - Reset (reset=0, async): all slot state = 0; CountEnM=0; LCOFIRequestM=0; EventReadValM=0.
//    Assertion mid-operation clears state in the same instant; first update on the first clk edge after deassertion.
//  - CountEnM[i] (combinational, 0-cycle latency) = EventSrcM[SEL_i] & ~inhibit_i, where inhibit_i is selected by mode:
//    M:MINH; S,V=0:SINH; U,V=0:UINH; S,V=1:VSINH; U,V=1:VUINH. A config write takes effect the cycle after the write edge.
//  - Overflow: CounterOvfM[i] in cycle N -> OF_i=1 at edge N+1 (sticky).
//    LCOFIRequestM=1 in cycle N iff some i has CounterOvfM[i]=1 & OF_i=0 & no same-cycle write to slot i's OF half.
//    A counter that wraps again while OF_i=1 raises no request.
//  - Simultaneous CSR write to a slot's OF-bearing register and CounterOvfM[i]: write data wins for OF, no LCOFI pulse.
//    Software writing OF=1 never raises LCOFI.
//  - RV32: the mhpmevent write updates SEL only; the mhpmeventh write updates OF/INH only.
//  - scountovf (0xDA0), read-only: bit i = OF_i & MCOUNTEREN_REGW[i] for i>=3, bits 2:0 = 0.
//    Legal in M and S (incl. VS), illegal in U/VU. A write is illegal and leaves state unchanged.
//  - Read mux, combinational: slots >=COUNTERS and mhpmevent1/2 read 0 with EventHitM=1; unrelated addresses read 0, EventHitM=0.
//  - No FSM beyond the per-slot OF state (CLEAR->SET on overflow or write 1; SET->CLEAR only on software write 0).
// STRUCTURE
//  - Package cvw: localparams HPMEV_OF/MINH/SINH/UINH/VSINH/VUINH bit positions, MHPMEVENTBASE=0x323,
//    MHPMEVENTHBASE=0x723, SCOUNTOVF=0xDA0; typedef hpmevent_t struct {of,minh,sinh,uinh,vsinh,vuinh,sel[7:0]}.
//  - One sub-module hpmevent_slot: holds one hpmevent_t, does its write decode, mode filter and OF update, and emits
//    CountEn and a new-overflow flag. Generated for i=3..COUNTERS-1; top does the read mux, scountovf and LCOFI OR-reduce.
// TESTING
//  - Reset: pulse reset low between edges mid-run -> all CountEnM/EventReadValM/LCOFIRequestM 0 immediately; mhpmevent5 reads 0.
//  - Select/filter: write mhpmevent3=0x05 in M, pulse EventSrcM[5] -> CountEnM[3]=1; set MINH (RV64 0x4000_0000_0000_0005)
//    -> CountEnM[3]=0 in M, 1 in S,V=0.
//  - Virtual filter: mhpmevent4=VSINH|0x07, S with V=1 and EventSrcM[7]=1 -> CountEnM[4]=0; same event in S with V=0 -> 1.
//  - Overflow: CounterOvfM[6]=1 in cycle N -> LCOFIRequestM=1 in N; mhpmevent6 bit63=1 from N+1; second wrap -> no pulse.
//  - Collision: write mhpmevent6 with OF=0 while CounterOvfM[6]=1 -> OF reads 0 next cycle, LCOFIRequestM=0.
//  - scountovf: OF3=OF9=1, MCOUNTEREN=0x200 -> S read 0x200; U read -> IllegalEventAccessM=1; S write 0xDA0 -> illegal, OF unchanged.

Source files
------------

// File: rtl/hpm_event_ctrl_pkg.sv
// rtl/hpm_event_ctrl_pkg.sv - shared HPM event field positions, CSR addresses and slot record
package cvw;

  localparam int HPMEV_OF    = 63;
  localparam int HPMEV_MINH  = 62;
  localparam int HPMEV_SINH  = 61;
  localparam int HPMEV_UINH  = 60;
  localparam int HPMEV_VSINH = 59;
  localparam int HPMEV_VUINH = 58;

  localparam logic [11:0] MHPMEVENTBASE  = 12'h323;
  localparam logic [11:0] MHPMEVENTHBASE = 12'h723;
  localparam logic [11:0] SCOUNTOVF      = 12'hDA0;

  typedef struct packed {
    logic       of;
    logic       minh;
    logic       sinh;
    logic       uinh;
    logic       vsinh;
    logic       vuinh;
    logic [7:0] sel;
  } hpmevent_t;

  // RV64 image of one mhpmevent; the RV32 high half is bits 63:32 of the same image.
  function automatic logic [63:0] hpmevent_pack(input hpmevent_t ev);
    return {ev.of, ev.minh, ev.sinh, ev.uinh, ev.vsinh, ev.vuinh, 50'b0, ev.sel};
  endfunction

endpackage

// File: rtl/hpmevent_slot.sv
// rtl/hpmevent_slot.sv - one mhpmevent slot: config storage, privilege filter, sticky overflow
module hpmevent_slot
  import cvw::*;
#(
  parameter int XLEN      = 64,
  parameter int IDX       = 3,
  parameter int NUMEVENTS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [11:0]          adr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [1:0]           priv,
  input  logic                 virt,
  input  logic [NUMEVENTS-1:0] event_src,
  input  logic                 ovf,
  output logic                 count_en,
  output logic                 new_ovf,
  output hpmevent_t            ev
);

  localparam logic [11:0] LO_ADR = MHPMEVENTBASE + 12'(IDX - 3);
  localparam logic [11:0] HI_ADR = MHPMEVENTHBASE + 12'(IDX - 3);

  logic        lo_wr, hi_wr, flag_wr, inhibit;
  logic [63:0] flags;
  logic [255:0] src_ext;

  assign lo_wr   = we & (adr == LO_ADR);
  assign hi_wr   = (XLEN == 32) & we & (adr == HI_ADR);
  assign flag_wr = (XLEN == 64) ? lo_wr : hi_wr;
  // Align the flag-bearing word to RV64 bit positions so one decode serves both widths.
  assign flags   = (XLEN == 64) ? 64'(wdata) : {wdata[31:0], 32'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev <= '0;
    end else begin
      if (lo_wr) ev.sel <= wdata[7:0];
      if (flag_wr) begin
        ev.of    <= flags[HPMEV_OF];
        ev.minh  <= flags[HPMEV_MINH];
        ev.sinh  <= flags[HPMEV_SINH];
        ev.uinh  <= flags[HPMEV_UINH];
        ev.vsinh <= flags[HPMEV_VSINH];
        ev.vuinh <= flags[HPMEV_VUINH];
      end else if (ovf) begin
        ev.of <= 1'b1;
      end
    end
  end

  always_comb begin
    inhibit = 1'b1;
    case (priv)
      2'b11: inhibit = ev.minh;
      2'b01: inhibit = virt ? ev.vsinh : ev.sinh;
      2'b00: inhibit = virt ? ev.vuinh : ev.uinh;
      default: inhibit = 1'b1;
    endcase
  end

  // Selector 0 and out-of-range selectors land on zero bits of the widened source vector.
  assign src_ext  = 256'(event_src) & ~256'd1;
  assign count_en = src_ext[ev.sel] & ~inhibit;
  assign new_ovf  = ovf & ~ev.of & ~flag_wr;

endmodule

// File: rtl/hpm_event_ctrl.sv
// rtl/hpm_event_ctrl.sv - HPM event selection, overflow tracking, LCOFI and scountovf
module hpm_event_ctrl
  import cvw::*;
#(
  parameter int XLEN      = 64,
  parameter int COUNTERS  = 32,
  parameter int NUMEVENTS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CSRMWriteM,
  input  logic [11:0]          CSRAdrM,
  input  logic [XLEN-1:0]      CSRWriteValM,
  input  logic [1:0]           PrivilegeModeW,
  input  logic                 VirtModeW,
  input  logic [31:0]          MCOUNTEREN_REGW,
  input  logic [NUMEVENTS-1:0] EventSrcM,
  input  logic [COUNTERS-1:0]  CounterOvfM,
  output logic [COUNTERS-1:0]  CountEnM,
  output logic [XLEN-1:0]      EventReadValM,
  output logic                 EventHitM,
  output logic                 IllegalEventAccessM,
  output logic                 LCOFIRequestM
);

  localparam logic [11:0] EV_LO_FIRST = MHPMEVENTBASE - 12'd2;
  localparam logic [11:0] EV_LO_LAST  = MHPMEVENTBASE + 12'd28;
  localparam logic [11:0] EV_HI_FIRST = MHPMEVENTHBASE - 12'd2;
  localparam logic [11:0] EV_HI_LAST  = MHPMEVENTHBASE + 12'd28;

  hpmevent_t             ev [COUNTERS];
  logic [COUNTERS-1:0]   new_ovf, of_vec;
  logic [63:0]           packed_ev;
  logic [4:0]            idx;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_fixed
      assign ev[g]       = '0;
      assign new_ovf[g]  = 1'b0;
      assign CountEnM[g] = 1'b0;
    end
    for (g = 3; g < COUNTERS; g++) begin : g_slot
      hpmevent_slot #(.XLEN(XLEN), .IDX(g), .NUMEVENTS(NUMEVENTS)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .we        (CSRMWriteM),
        .adr       (CSRAdrM),
        .wdata     (CSRWriteValM),
        .priv      (PrivilegeModeW),
        .virt      (VirtModeW),
        .event_src (EventSrcM),
        .ovf       (CounterOvfM[g]),
        .count_en  (CountEnM[g]),
        .new_ovf   (new_ovf[g]),
        .ev        (ev[g])
      );
    end
    for (g = 0; g < COUNTERS; g++) begin : g_of
      assign of_vec[g] = ev[g].of;
    end
  endgenerate

  // Request is gated by reset so a carry arriving during reset cannot leak out.
  assign LCOFIRequestM = reset & (|new_ovf);

  assign IllegalEventAccessM = (CSRAdrM == SCOUNTOVF) & (CSRMWriteM | (PrivilegeModeW == 2'b00));

  assign idx = CSRAdrM[4:0];

  always_comb begin
    packed_ev = '0;
    for (int i = 3; i < COUNTERS; i++) begin
      if (idx == 5'(i)) packed_ev = hpmevent_pack(ev[i]);
    end
  end

  always_comb begin
    EventReadValM = '0;
    EventHitM     = 1'b0;
    if (CSRAdrM >= EV_LO_FIRST && CSRAdrM <= EV_LO_LAST) begin
      EventHitM     = 1'b1;
      EventReadValM = packed_ev[XLEN-1:0];
    end else if (XLEN == 32 && CSRAdrM >= EV_HI_FIRST && CSRAdrM <= EV_HI_LAST) begin
      EventHitM     = 1'b1;
      EventReadValM = packed_ev[63:64-XLEN];
    end else if (CSRAdrM == SCOUNTOVF) begin
      EventHitM     = 1'b1;
      EventReadValM = XLEN'(of_vec & MCOUNTEREN_REGW[COUNTERS-1:0]);
    end
  end

endmodule

// File: tb/tb_hpm_event_ctrl.sv
// tb/tb_hpm_event_ctrl.sv - directed self-checking bench for hpm_event_ctrl
module tb_hpm_event_ctrl;

  logic        clk;
  logic        reset;
  logic        CSRMWriteM;
  logic [11:0] CSRAdrM;
  logic [63:0] CSRWriteValM;
  logic [1:0]  PrivilegeModeW;
  logic        VirtModeW;
  logic [31:0] MCOUNTEREN_REGW;
  logic [31:0] EventSrcM;
  logic [31:0] CounterOvfM;
  logic [31:0] CountEnM;
  logic [63:0] EventReadValM;
  logic        EventHitM;
  logic        IllegalEventAccessM;
  logic        LCOFIRequestM;

  int checks = 0;
  int errors = 0;

  hpm_event_ctrl #(.XLEN(64), .COUNTERS(32), .NUMEVENTS(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .CSRMWriteM          (CSRMWriteM),
    .CSRAdrM             (CSRAdrM),
    .CSRWriteValM        (CSRWriteValM),
    .PrivilegeModeW      (PrivilegeModeW),
    .VirtModeW           (VirtModeW),
    .MCOUNTEREN_REGW     (MCOUNTEREN_REGW),
    .EventSrcM           (EventSrcM),
    .CounterOvfM         (CounterOvfM),
    .CountEnM            (CountEnM),
    .EventReadValM       (EventReadValM),
    .EventHitM           (EventHitM),
    .IllegalEventAccessM (IllegalEventAccessM),
    .LCOFIRequestM       (LCOFIRequestM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    CSRAdrM = a; CSRWriteValM = d; CSRMWriteM = 1'b1;
    @(posedge clk);
    #1 CSRMWriteM = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [63:0] exp);
    CSRAdrM = a;
    #1 check(tag, EventReadValM, exp);
  endtask

  initial begin
    reset = 1'b0; CSRMWriteM = 1'b0; CSRAdrM = '0; CSRWriteValM = '0;
    PrivilegeModeW = 2'b11; VirtModeW = 1'b0; MCOUNTEREN_REGW = '0;
    EventSrcM = '0; CounterOvfM = '0;

    #12;
    check("reset_counten", CountEnM, 0);
    check("reset_lcofi", LCOFIRequestM, 0);
    read_check("reset_ev5", 12'h325, 0);
    @(negedge clk); reset = 1'b1;

    // Select and M-mode inhibit on slot 3
    csr_write(12'h323, 64'h5);
    @(negedge clk); EventSrcM = 32'h20;
    #1 check("sel_m_counten", CountEnM, 32'h8);
    read_check("sel_readback", 12'h323, 64'h5);
    csr_write(12'h323, 64'h4000_0000_0000_0005);
    @(negedge clk);
    #1 check("minh_m", CountEnM, 0);
    PrivilegeModeW = 2'b01; VirtModeW = 1'b0;
    #1 check("minh_s", CountEnM, 32'h8);

    // Virtual-supervisor inhibit on slot 4
    csr_write(12'h324, 64'h0800_0000_0000_0007);
    @(negedge clk); EventSrcM = 32'h80; VirtModeW = 1'b1;
    #1 check("vsinh_vs", CountEnM, 0);
    VirtModeW = 1'b0;
    #1 check("vsinh_s", CountEnM, 32'h10);
    EventSrcM = '0;

    // Overflow on slot 6, then a second wrap
    @(negedge clk); CounterOvfM = 32'h40;
    #1 check("ovf_lcofi", LCOFIRequestM, 1);
    read_check("ovf_of_before", 12'h326, 0);
    @(posedge clk); #1;
    check("ovf2_lcofi", LCOFIRequestM, 0);
    read_check("ovf_of_after", 12'h326, 64'h8000_0000_0000_0000);
    @(negedge clk); CounterOvfM = '0;

    // Collision: write OF=0 with a carry on slot 8
    @(negedge clk);
    CSRAdrM = 12'h328; CSRWriteValM = '0; CSRMWriteM = 1'b1; CounterOvfM = 32'h100;
    #1 check("coll_lcofi", LCOFIRequestM, 0);
    @(posedge clk); #1 CSRMWriteM = 1'b0; CounterOvfM = '0;
    read_check("coll_of", 12'h328, 0);
    csr_write(12'h326, 64'h0);
    read_check("clear_of6", 12'h326, 0);

    // Software OF=1 on slot 3 raises nothing; hardware carry on slot 9
    @(negedge clk);
    CSRAdrM = 12'h323; CSRWriteValM = 64'h8000_0000_0000_0005; CSRMWriteM = 1'b1;
    #1 check("swof_lcofi", LCOFIRequestM, 0);
    @(posedge clk); #1 CSRMWriteM = 1'b0;
    read_check("swof_read", 12'h323, 64'h8000_0000_0000_0005);
    @(negedge clk); CounterOvfM = 32'h200;
    #1 check("of9_lcofi", LCOFIRequestM, 1);
    @(posedge clk); #1 CounterOvfM = '0;

    // scountovf visibility and legality
    @(negedge clk); MCOUNTEREN_REGW = 32'h200; PrivilegeModeW = 2'b01; VirtModeW = 1'b0;
    read_check("scovf_s", 12'hDA0, 64'h200);
    check("scovf_s_hit", EventHitM, 1);
    check("scovf_s_legal", IllegalEventAccessM, 0);
    VirtModeW = 1'b1;
    read_check("scovf_vs", 12'hDA0, 64'h200);
    check("scovf_vs_legal", IllegalEventAccessM, 0);
    PrivilegeModeW = 2'b00; VirtModeW = 1'b0;
    #1 check("scovf_u_illegal", IllegalEventAccessM, 1);
    @(negedge clk); PrivilegeModeW = 2'b01;
    CSRAdrM = 12'hDA0; CSRWriteValM = '0; CSRMWriteM = 1'b1;
    #1 check("scovf_wr_illegal", IllegalEventAccessM, 1);
    @(posedge clk); #1 CSRMWriteM = 1'b0;
    MCOUNTEREN_REGW = 32'hFFFF_FFFF;
    read_check("scovf_after_wr", 12'hDA0, 64'h208);

    // Read decode boundaries
    read_check("ev1_read", 12'h321, 0);
    check("ev1_hit", EventHitM, 1);
    read_check("ev31_read", 12'h33F, 0);
    check("ev31_hit", EventHitM, 1);
    read_check("beyond_read", 12'h340, 0);
    check("beyond_hit", EventHitM, 0);
    CSRAdrM = 12'h320;
    #1 check("inhibit_hit", EventHitM, 0);

    // Mid-run asynchronous reset
    @(negedge clk); EventSrcM = 32'h20; CSRAdrM = 12'h323;
    #1 check("pre_reset_counten", CountEnM, 32'h8);
    #2 reset = 1'b0; CounterOvfM = 32'h20;
    #1 check("mid_reset_counten", CountEnM, 0);
    check("mid_reset_lcofi", LCOFIRequestM, 0);
    check("mid_reset_ev3", EventReadValM, 0);
    read_check("mid_reset_ev5", 12'h325, 0);
    read_check("mid_reset_scovf", 12'hDA0, 0);
    @(negedge clk); reset = 1'b1; CounterOvfM = '0; EventSrcM = '0;
    @(posedge clk); #1;
    read_check("post_reset_ev3", 12'h323, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
